// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter between the CPU and a debug/loader master for the shared
// 64-word memory; one latched transaction runs through IDLE -> ACCESS [-> RESP].
module mem_port_arbiter #(
  parameter int ADDR_W   = 6,
  parameter int DATA_W   = 32,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic              dbg_lock,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [ADDR_W-1:0] mem_raddr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam int LCNT_W = ($clog2(LOCK_MAX + 1) > 4) ? $clog2(LOCK_MAX + 1) : 4;
  localparam logic [LCNT_W-1:0] LOCK_LIM = LCNT_W'(LOCK_MAX);

  logic [1:0]        state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LCNT_W-1:0] lock_cnt_q, lock_cnt_d;

  logic lock_hold;
  logic dbg_wins;
  logic grant_cpu;
  logic grant_dbg;

  // Debug keeps the port only while it already owns it and the burst budget remains.
  assign lock_hold = dbg_lock && owner_q && (lock_cnt_q < LOCK_LIM);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lock_cnt_d = lock_cnt_q;
    dbg_wins   = 1'b0;
    grant_cpu  = 1'b0;
    grant_dbg  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          if (cpu_req && dbg_req) begin
            dbg_wins = lock_hold || !owner_q;
          end else begin
            dbg_wins = dbg_req;
          end
          grant_dbg = dbg_wins;
          grant_cpu = !dbg_wins;
          owner_d   = dbg_wins;
          we_d      = dbg_wins ? dbg_we    : cpu_we;
          addr_d    = dbg_wins ? dbg_addr  : cpu_addr;
          wdata_d   = dbg_wins ? dbg_wdata : cpu_wdata;
          state_d   = S_ACCESS;
        end
      end
      S_ACCESS: state_d = we_q ? S_IDLE : S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (!dbg_lock || grant_cpu) begin
      lock_cnt_d = '0;
    end else if (grant_dbg && cpu_req && (lock_cnt_q < LOCK_LIM)) begin
      lock_cnt_d = lock_cnt_q + LCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      owner_q    <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  logic done;

  // Reset in the same cycle kills both the write strobe and the completion pulse.
  assign done      = !rst && (((state_q == S_ACCESS) && we_q) || (state_q == S_RESP));
  assign mem_we    = !rst && (state_q == S_ACCESS) && we_q;
  assign mem_waddr = addr_q;
  assign mem_raddr = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_ack   = done && !owner_q;
  assign dbg_ack   = done && owner_q;
  assign cpu_rdata = mem_rdata;
  assign dbg_rdata = mem_rdata;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a queue of expected grants is filled by
// the stimulus and drained by a monitor that checks every ack against it.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [5:0]  cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_ack;
  logic [31:0] cpu_rdata;
  logic        dbg_req, dbg_we, dbg_lock;
  logic [5:0]  dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_ack;
  logic [31:0] dbg_rdata;
  logic        mem_we;
  logic [5:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [5:0]  mem_raddr;
  logic [31:0] mem_rdata;
  logic        busy, owner;

  mem_port_arbiter #(.ADDR_W(6), .DATA_W(32), .LOCK_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
    .dbg_wdata(dbg_wdata), .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory: write port A, registered read port B; preset to A500_00xx.
  logic        mem_init;
  logic [31:0] mem [64];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'hA500_0000 | i;
    end else if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
    mem_rdata <= mem[mem_raddr];
  end

  typedef struct {
    bit          who;
    bit          rd;
    logic [5:0]  addr;
    logic [31:0] data;
    int          gap;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic push(input bit who, input bit rd, input logic [5:0] addr,
                      input logic [31:0] data, input int gap);
    exp_t e;
    e.who = who; e.rd = rd; e.addr = addr; e.data = data; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    int   last_ack = 0;
    forever begin
      @(negedge clk);
      if (cpu_ack || dbg_ack) begin
        check("single_ack", 32'(cpu_ack && dbg_ack), 32'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", {30'd0, dbg_ack, cpu_ack}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("ack_owner", 32'(dbg_ack), 32'(e.who));
          check("owner_out", 32'(owner), 32'(e.who));
          if (e.rd) begin
            check("raddr", 32'(mem_raddr), 32'(e.addr));
            check("rdata", e.who ? dbg_rdata : cpu_rdata, e.data);
          end else begin
            check("wr_mem_we", 32'(mem_we), 32'd1);
            check("wr_waddr", 32'(mem_waddr), 32'(e.addr));
            check("wr_wdata", mem_wdata, e.data);
          end
          if (e.gap != 0) check("ack_gap", 32'(cyc - last_ack), 32'(e.gap));
        end
        last_ack = cyc;
      end
    end
  endtask

  task automatic cpu_do(input logic we, input logic [5:0] addr, input logic [31:0] wd,
                        output int req_cyc, output int ack_cyc);
    bit seen = 0;
    req_cyc = cyc; ack_cyc = -1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (cpu_ack) begin seen = 1; ack_cyc = cyc; end
    end
    check("cpu_ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic dbg_do(input logic we, input logic lock, input logic [5:0] addr,
                        input logic [31:0] wd, output int req_cyc, output int ack_cyc);
    bit seen = 0;
    req_cyc = cyc; ack_cyc = -1;
    dbg_req = 1'b1; dbg_we = we; dbg_lock = lock; dbg_addr = addr; dbg_wdata = wd;
    for (int k = 0; k < 80 && !seen; k++) begin
      @(negedge clk);
      if (dbg_ack) begin seen = 1; ack_cyc = cyc; end
    end
    check("dbg_ack_seen", 32'(seen), 32'd1);
    @(posedge clk); #1;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_lock = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int rq, ak, rq2, ak2, t0;
    rst = 1'b1; mem_init = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_lock = 0; dbg_addr = '0; dbg_wdata = '0;
    fork monitor_loop(); join_none

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd1);
    check("rst_cpu_ack", 32'(cpu_ack), 32'd0);
    check("rst_dbg_ack", 32'(dbg_ack), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_waddr", 32'(mem_waddr), 32'd0);
    check("rst_raddr", 32'(mem_raddr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0; mem_init = 1'b0;

    // CPU write then read-back of addr 5
    push(0, 0, 6'd5, 32'hDEAD_BEEF, 0);
    cpu_do(1'b1, 6'd5, 32'hDEAD_BEEF, rq, ak);
    check("wr_latency", 32'(ak - rq + 1), 32'd2);
    push(0, 1, 6'd5, 32'hDEAD_BEEF, 0);
    cpu_do(1'b0, 6'd5, 32'h0, rq, ak);
    check("rd_latency", 32'(ak - rq + 1), 32'd3);

    // Both requesting reads continuously, no lock: strict alternation from CPU
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push(0, 1, 6'(10 + i), 32'hA500_0000 | (10 + i), (i == 0) ? 0 : 3);
      push(1, 1, 6'(20 + i), 32'hA500_0000 | (20 + i), 3);
    end
    fork
      for (int i = 0; i < 3; i++) cpu_do(1'b0, 6'(10 + i), 32'h0, rq, ak);
      for (int i = 0; i < 3; i++) dbg_do(1'b0, 1'b0, 6'(20 + i), 32'h0, rq2, ak2);
    join

    // Locked debug burst vs. CPU writes: 8 DBG, CPU, 8 DBG, CPU
    do_reset();
    for (int i = 0; i < 8; i++) push(1, 0, 6'(i), 32'hB000_0000 + i, (i == 0) ? 0 : 2);
    push(0, 0, 6'd40, 32'hC0DE_0040, 2);
    for (int i = 8; i < 16; i++) push(1, 0, 6'(i), 32'hB000_0000 + i, 2);
    push(0, 0, 6'd41, 32'hC0DE_0041, 2);
    fork
      for (int i = 0; i < 16; i++) dbg_do(1'b1, 1'b1, 6'(i), 32'hB000_0000 + i, rq2, ak2);
      begin
        cpu_do(1'b1, 6'd40, 32'hC0DE_0040, rq, ak);
        cpu_do(1'b1, 6'd41, 32'hC0DE_0041, rq, ak);
      end
    join

    // Locked debug burst with CPU idle: 16 back-to-back writes
    for (int i = 16; i < 32; i++) push(1, 0, 6'(i), 32'hD000_0000 + i, (i == 16) ? 0 : 2);
    for (int i = 16; i < 32; i++) dbg_do(1'b1, 1'b1, 6'(i), 32'hD000_0000 + i, rq2, ak2);

    // Reset during the ACCESS cycle of a CPU write to addr 3
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd3; cpu_wdata = 32'h1234_5678;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("rst_access_mem_we", 32'(mem_we), 32'd0);
    check("rst_access_ack", 32'(cpu_ack), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    check("rst_access_busy", 32'(busy), 32'd0);
    push(0, 1, 6'd3, 32'hB000_0003, 0);
    cpu_do(1'b0, 6'd3, 32'h0, rq, ak);
    check("rst_access_rd_lat", 32'(ak - rq + 1), 32'd3);

    // CPU request raised while a debug read sits in RESP
    push(1, 1, 6'd16, 32'hD000_0010, 0);
    push(0, 1, 6'd5, 32'hB000_0005, 3);
    t0 = cyc;
    fork
      dbg_do(1'b0, 1'b0, 6'd16, 32'h0, rq2, ak2);
      begin
        repeat (2) @(posedge clk);
        #1;
        cpu_do(1'b0, 6'd5, 32'h0, rq, ak);
      end
    join
    check("dbg_rd_resp_cycle", 32'(ak2 - t0), 32'd2);
    check("cpu_after_idle_lat", 32'(ak - (t0 + 3) + 1), 32'd3);

    repeat (4) @(posedge clk);
    #1;
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the shared 64-word unified memory between the multi-cycle CPU (instruction fetch and load/store) and a debug/loader master. Each requester sees a request/acknowledge handshake. The arbiter drives the memory's write port (A) and registered read port (B) from one latched transaction at a time. Round-robin fairness applies, and the debug master gets a bounded lock for burst program loading. It sits between the CPU datapath/control and the memory instance, replacing the direct IorD address mux.

## Interface
- ADDR_W, 6, word address width (64 words)
- DATA_W, 32, data width
- LOCK_MAX, 8, max consecutive debug grants under lock while the CPU is waiting

- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- cpu_req, cpu_we  in  1  CPU request; 1 = write
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DATA_W  read data, valid only while cpu_ack=1 on a read
- dbg_req, dbg_we, dbg_lock  in  1  debug request, write flag, burst lock
- dbg_addr  in  ADDR_W  debug word address
- dbg_wdata  in  DATA_W  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DATA_W  read data, valid only while dbg_ack=1 on a read
- mem_we  out  1  memory port A write enable
- mem_waddr  out  ADDR_W  port A address
- mem_wdata  out  DATA_W  port A data
- mem_raddr  out  ADDR_W  port B address
- mem_rdata  in  DATA_W  port B data, registered by memory (1-cycle latency)
- busy  out  1  high whenever state != IDLE
- owner  out  1  0 = CPU, 1 = debug; current or last grant

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No requests: stay in IDLE.
  - Any request: pick a winner, latch its we/addr/wdata, set owner, go to ACCESS.
- Arbitration when both requesters are asserted:
  - Default: the requester not granted last wins (round-robin on owner).
  - Lock override: if dbg_lock=1, owner=1 and lock_cnt<LOCK_MAX, debug wins.
- ACCESS:
  - mem_raddr and mem_waddr are driven from the latched address.
  - Write: mem_we=1, mem_wdata = latched data, winner's ack=1, next state IDLE.
  - Read: mem_we=0, next state RESP.
- RESP: winner's ack=1, winner's rdata = mem_rdata, next state IDLE.
- The losing requester's ack stays 0; its rdata is don't-care (drive mem_rdata).
- lock_cnt (4-bit minimum):
  - Increments on each debug grant made while dbg_lock=1 and cpu_req=1.
  - Clears on any CPU grant or whenever dbg_lock=0.
  - Saturates at LOCK_MAX.
- Requester rules:
  - Hold req, we, addr and wdata stable from assertion until ack.
  - Deassert req in the cycle after ack unless issuing a new access.
  - Requests are not cancellable once granted.
- mem_we depends only on state and the latched we; it never follows live requester inputs.

## Timing
- Reset values:
  - state=IDLE, owner=1 (so the CPU wins the first tie), lock_cnt=0.
  - mem_we=0, mem_waddr=0, mem_raddr=0, mem_wdata=0.
  - cpu_ack=dbg_ack=0, busy=0.
- Write latency: req sampled at edge N, ACCESS in cycle N+1 (ack high), write commits at edge N+2. Total 2 cycles req→ack.
- Read latency: ACCESS in cycle N+1, RESP in cycle N+2 (ack high, data valid). Total 3 cycles.
- Back-to-back throughput:
  - Minimum 1 idle cycle between transactions, since IDLE is always visited.
  - Maximum: 1 write per 2 cycles, 1 read per 3 cycles.
- Simultaneous first requests after reset: CPU is granted.
- Requests arriving during ACCESS/RESP are held pending and are not sampled until IDLE.
- rst during ACCESS: mem_we is forced 0 in that cycle (gated by rst), so no write commits. All state returns to reset values at the edge.
- rst during RESP: the ack is suppressed in that cycle; the transaction is dropped.
- Address width has no overflow handling; addresses wrap within the 2^ADDR_W word space.

## Test plan
- Reset, then CPU write of 0xDEADBEEF to addr 5:
  - cpu_ack pulses 2 cycles after req, with mem_we=1, mem_waddr=5 in that cycle.
  - A following CPU read of addr 5 returns 0xDEADBEEF with cpu_ack 3 cycles after req.
- cpu_req and dbg_req both asserted continuously, reads, dbg_lock=0:
  - Grants alternate CPU, DBG, CPU, DBG…, starting with CPU.
  - Each ack is 3 cycles apart within its transaction, with 1 idle cycle between transactions.
- dbg_lock=1 with a debug write burst to addrs 0..15 while cpu_req is held:
  - Exactly 8 debug grants occur, then one CPU grant, then debug resumes.
  - lock_cnt restarts after the CPU grant.
- dbg_lock=1 with cpu_req=0: debug writes 16 consecutive words; no CPU grant occurs and lock_cnt stays 0.
- rst asserted during the ACCESS cycle of a write of 0x12345678 to addr 3:
  - mem_we=0 in that cycle, and a later read of addr 3 returns the prior value.
  - No ack is issued, and busy=0 after the edge.
- cpu_req raised while a debug read is in RESP: the CPU is granted in the following IDLE arbitration, and cpu_ack arrives 3 cycles after IDLE.
